uart_rx: RTL

Receive half of the UART link: recovers serial frames from the `rx` line and buffers complete data words in an on-chip FIFO. It uses a 16x baud oversampling tick and the same frame format and parameters as the transmit path. The block sits between the `rx` pin and the host-side consumer, which drains it with a read-enable / empty handshake. Framing errors and FIFO overruns are reported as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Host-side handshake of the UART receiver: read-enable/empty FIFO port plus
// the frame-error and overrun status pulses.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rd_en;
  logic [DATA_BITS-1:0] d_out;
  logic                 empty;
  logic                 full;
  logic                 frame_err;
  logic                 overrun;

  modport slave (
    input  rd_en,
    output d_out, empty, full, frame_err, overrun
  );

  modport master (
    output rd_en,
    input  d_out, empty, full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled frame recovery into a read-enable FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote of ticks 7, 8 and 9.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.slave host
);

  localparam int unsigned DIV  = CLOCK_FREQ / (BAUD * 16);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SampleTick = 4'd9;
`else
  localparam logic [3:0] SampleTick = 4'd7;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_s_d_q;
  logic [1:0]           settle_q, settle_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop_ok_q, stop_ok_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, wrap, sample, bit_val, fall, stop_ok_now;
  logic empty, full, rd, wr_en;

`ifdef UART_RX_MAJORITY_EN
  logic s7_q, s7_d, s8_q, s8_d;
`endif

  always_comb begin
    tick   = (div_q == DivW'(DIV - 1));
    wrap   = tick && (tcnt_q == 4'd15);
    sample = tick && (tcnt_q == SampleTick);
`ifdef UART_RX_MAJORITY_EN
    bit_val = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
`else
    bit_val = rx_s_q;
`endif
    // The synchronizer resets to 1, so ignore edges until it holds real line data.
    fall        = (settle_q == 2'd3) && rx_s_d_q && !rx_s_q;
    stop_ok_now = stop_ok_q & bit_val;
    empty       = (count_q == '0);
    full        = (count_q == CntW'(FIFO_DEPTH));
    rd          = host.rd_en && !empty;

    state_d     = state_q;
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    div_d       = tick ? '0 : div_q + DivW'(1);
    tcnt_d      = tick ? tcnt_q + 4'd1 : tcnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    stop_ok_d   = stop_ok_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    s7_d = (tick && tcnt_q == 4'd7) ? rx_s_q : s7_q;
    s8_d = (tick && tcnt_q == 4'd8) ? rx_s_q : s8_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          div_d   = '0;
          tcnt_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (sample && bit_val) begin
          state_d = StIdle;
        end else if (wrap) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (sample) shift_d[bit_idx_q] = bit_val;
        if (wrap) begin
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
            stop_ok_d  = 1'b1;
            state_d    = StStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StStop: begin
        if (sample) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            // Decide mid-stop-bit so the next start edge is not missed.
            state_d = StIdle;
            if (!stop_ok_now)   frame_err_d = 1'b1;
            else if (full)      overrun_d   = 1'b1;
            else                wr_en       = 1'b1;
          end else begin
            stop_ok_d = stop_ok_now;
          end
        end else if (wrap) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    d_out_d  = rd ? mem_q[rd_ptr_q] : d_out_q;
    count_d  = count_q + CntW'(wr_en) - CntW'(rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_d_q    <= 1'b1;
      settle_q    <= '0;
      div_q       <= '0;
      tcnt_q      <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      stop_ok_q   <= 1'b1;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      d_out_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_s_d_q    <= rx_s_q;
      settle_q    <= settle_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      stop_ok_q   <= stop_ok_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      d_out_q     <= d_out_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
      s7_q        <= s7_d;
      s8_q        <= s8_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign host.d_out     = d_out_q;
  assign host.empty     = empty;
  assign host.full      = full;
  assign host.frame_err = frame_err_q;
  assign host.overrun   = overrun_q;

endmodule
